// File: rtl/pc_gen_if.sv
// Fetch-request bus between the program counter and the instruction memory.
// The master side (pc_gen) issues pc_o; the slave side accepts with fetch_ready_i.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_valid_o;
  logic              fetch_ready_i;
  logic [ADDR_W-1:0] pc_o;
  logic              redirect_o;

  modport master (
    output fetch_valid_o,
    output pc_o,
    output redirect_o,
    input  fetch_ready_i
  );

  modport slave (
    input  fetch_valid_o,
    input  pc_o,
    input  redirect_o,
    output fetch_ready_i
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter at the head of fetch: valid/ready fetch requests, trap/jump
// redirects with a pending buffer for stalls, and a debug halt/resume FSM.
module pc_gen #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit                C_EXT    = 1'b1,
  parameter int                HOLD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jtag_reset_i,
  input  logic              halt_req_i,
  output logic              halted_o,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              comp_i,
  pc_gen_if.master          fetch_bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] pend_addr_reg, pend_addr_next;
  logic              pend_valid_reg, pend_valid_next;
  logic              pend_trap_reg, pend_trap_next;
  logic              redirect_reg, redirect_next;

  logic              fetch_valid;
  logic              accept;
  logic [ADDR_W-1:0] trap_tgt;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] step;

  // Targets are forced onto an instruction boundary before they reach pc.
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] res;
    res = addr;
    res[0] = 1'b0;
    if (!C_EXT) res[1] = 1'b0;
    return res;
  endfunction

  assign fetch_valid = (state_reg == RUN);
  assign accept      = fetch_valid && fetch_bus.fetch_ready_i;
  assign trap_tgt    = align(trap_addr_i);
  assign jump_tgt    = align(jump_addr_i);
  assign step        = (C_EXT && comp_i) ? ADDR_W'(2) : ADDR_W'(4);

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pend_addr_next  = pend_addr_reg;
    pend_valid_next = pend_valid_reg;
    pend_trap_next  = pend_trap_reg;
    redirect_next   = 1'b0;

    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end

      RUN: begin
        if (accept) begin
          if (trap_flag_i) begin
            pc_next       = trap_tgt;
            redirect_next = 1'b1;
          end else if (jump_flag_i) begin
            pc_next       = jump_tgt;
            redirect_next = 1'b1;
          end else if (pend_valid_reg) begin
            pc_next       = pend_addr_reg;
            redirect_next = 1'b1;
          end else if (hold_flag_i == '0) begin
            pc_next = pc_reg + step;
          end
          // Any redirect taken here supersedes whatever was buffered.
          pend_valid_next = 1'b0;
          pend_trap_next  = 1'b0;
          if (halt_req_i) state_next = HALT;
        end else begin
          // Stalled: remember the newest redirect, but a jump may not displace a trap.
          if (trap_flag_i) begin
            pend_addr_next  = trap_tgt;
            pend_valid_next = 1'b1;
            pend_trap_next  = 1'b1;
          end else if (jump_flag_i && !(pend_valid_reg && pend_trap_reg)) begin
            pend_addr_next  = jump_tgt;
            pend_valid_next = 1'b1;
            pend_trap_next  = 1'b0;
          end
        end
      end

      HALT: begin
        if (trap_flag_i) begin
          pend_addr_next  = trap_tgt;
          pend_valid_next = 1'b1;
          pend_trap_next  = 1'b1;
        end
        if (!halt_req_i) begin
          state_next = RUN;
          if (trap_flag_i) begin
            pc_next       = trap_tgt;
            redirect_next = 1'b1;
          end else if (pend_valid_reg) begin
            pc_next       = pend_addr_reg;
            redirect_next = 1'b1;
          end
          pend_valid_next = 1'b0;
          pend_trap_next  = 1'b0;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || jtag_reset_i) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      pend_addr_reg  <= '0;
      pend_valid_reg <= 1'b0;
      pend_trap_reg  <= 1'b0;
      redirect_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pend_addr_reg  <= pend_addr_next;
      pend_valid_reg <= pend_valid_next;
      pend_trap_reg  <= pend_trap_next;
      redirect_reg   <= redirect_next;
    end
  end

  assign fetch_bus.fetch_valid_o = fetch_valid;
  assign fetch_bus.pc_o          = pc_reg;
  assign fetch_bus.redirect_o    = redirect_reg;
  assign halted_o                = (state_reg == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a C_EXT=1 and a C_EXT=0 instance share all stimulus;
// each cycle's expected outputs are queued with its stimulus and compared after the edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jtag_reset;
  logic        halt_req;
  logic        trap_flag;
  logic [31:0] trap_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold;
  logic        comp;
  logic        halted0;
  logic        halted1;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32)) bus0 ();
  pc_gen_if #(.ADDR_W(32)) bus1 ();

  pc_gen #(.ADDR_W(32), .RESET_PC(32'h0), .C_EXT(1'b1), .HOLD_W(3)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .jtag_reset_i (jtag_reset),
    .halt_req_i   (halt_req),
    .halted_o     (halted0),
    .trap_flag_i  (trap_flag),
    .trap_addr_i  (trap_addr),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .hold_flag_i  (hold),
    .comp_i       (comp),
    .fetch_bus    (bus0.master)
  );

  pc_gen #(.ADDR_W(32), .RESET_PC(32'h0), .C_EXT(1'b0), .HOLD_W(3)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .jtag_reset_i (jtag_reset),
    .halt_req_i   (halt_req),
    .halted_o     (halted1),
    .trap_flag_i  (trap_flag),
    .trap_addr_i  (trap_addr),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .hold_flag_i  (hold),
    .comp_i       (comp),
    .fetch_bus    (bus1.master)
  );

  typedef struct {
    logic        rst_n;
    logic        jtag;
    logic        halt;
    logic        trap;
    logic [31:0] taddr;
    logic        jump;
    logic [31:0] jaddr;
    logic [2:0]  hold;
    logic        comp;
    logic        ready;
  } stim_t;

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        valid;
    logic        redir;
    logic        halted;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic add(input logic r, input logic j, input logic h, input logic t,
                     input logic [31:0] ta, input logic jf, input logic [31:0] ja,
                     input logic [2:0] hd, input logic c, input logic rdy,
                     input logic [31:0] p0, input logic [31:0] p1,
                     input logic v, input logic rd, input logic hl);
    stim_t s;
    exp_t  e;
    s.rst_n = r;  s.jtag = j;   s.halt = h;  s.trap = t;  s.taddr = ta;
    s.jump = jf;  s.jaddr = ja; s.hold = hd; s.comp = c;  s.ready = rdy;
    e.pc0 = p0;   e.pc1 = p1;   e.valid = v; e.redir = rd; e.halted = hl;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    rst_n = s.rst_n;  jtag_reset = s.jtag; halt_req = s.halt;
    trap_flag = s.trap; trap_addr = s.taddr;
    jump_flag = s.jump; jump_addr = s.jaddr;
    hold = s.hold; comp = s.comp;
    bus0.fetch_ready_i = s.ready;
    bus1.fetch_ready_i = s.ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cyc = 0;
    add(0,0,0,0,0,0,0,3'd0,0,0, 32'h0,32'h0, 0,0,0);
    add(0,0,0,0,0,0,0,3'd0,0,1, 32'h0,32'h0, 0,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_reset cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_reset cyc %0d: pc=%h pc_c0=%h valid=%b", cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o);
      cyc++;
    end
  endtask

  task automatic test_sequential();
    int cyc = 0;
    // BOOT lasted the final reset-released cycle; first RUN shows pc 0.
    add(1,0,0,0,0,0,0,3'd0,0,1, 32'h0,32'h0, 1,0,0);
    add(1,0,0,0,0,0,0,3'd0,0,1, 32'h4,32'h4, 1,0,0);
    add(1,0,0,0,0,0,0,3'd0,0,1, 32'h8,32'h8, 1,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_sequential cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_sequential cyc %0d: pc=%h pc_c0=%h valid=%b", cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o);
      cyc++;
    end
  endtask

  task automatic test_comp();
    int cyc = 0;
    add(1,0,0,0,0,0,0,          3'd0,1,1, 32'hA,  32'hC,   1,0,0);
    add(1,0,0,0,0,1,32'h103,    3'd0,0,1, 32'h102,32'h100, 1,1,0);
    add(1,0,0,0,0,0,0,          3'd0,0,1, 32'h106,32'h104, 1,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_comp cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_comp cyc %0d: pc=%h pc_c0=%h redirect=%b", cyc, bus0.pc_o, bus1.pc_o, bus0.redirect_o);
      cyc++;
    end
  endtask

  task automatic test_stall();
    int cyc = 0;
    add(1,0,0,0,0,        1,32'h20,3'd0,0,1, 32'h20, 32'h20,  1,1,0);
    add(1,0,0,0,0,        1,32'h80,3'd0,0,0, 32'h20, 32'h20,  1,0,0);
    add(1,0,0,1,32'h200,  0,0,     3'd0,0,0, 32'h20, 32'h20,  1,0,0);
    add(1,0,0,0,0,        1,32'h90,3'd0,0,0, 32'h20, 32'h20,  1,0,0);
    add(1,0,0,0,0,        0,0,     3'd0,0,0, 32'h20, 32'h20,  1,0,0);
    add(1,0,0,0,0,        0,0,     3'd0,0,1, 32'h200,32'h200, 1,1,0);
    add(1,0,0,0,0,        0,0,     3'd0,0,1, 32'h204,32'h204, 1,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_stall cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_stall cyc %0d: pc=%h redirect=%b", cyc, bus0.pc_o, bus0.redirect_o);
      cyc++;
    end
  endtask

  task automatic test_trap_jump_hold();
    int cyc = 0;
    add(1,0,0,1,32'h400,1,32'h500,3'b010,0,1, 32'h400,32'h400, 1,1,0);
    add(1,0,0,0,0,      0,0,      3'b010,0,1, 32'h400,32'h400, 1,0,0);
    add(1,0,0,0,0,      0,0,      3'b010,0,1, 32'h400,32'h400, 1,0,0);
    add(1,0,0,0,0,      0,0,      3'b000,0,1, 32'h404,32'h404, 1,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_trap_jump_hold cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_trap_jump_hold cyc %0d: pc=%h redirect=%b", cyc, bus0.pc_o, bus0.redirect_o);
      cyc++;
    end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    add(1,0,0,0,0,1,32'hFFFF_FFFC,3'd0,0,1, 32'hFFFF_FFFC,32'hFFFF_FFFC, 1,1,0);
    add(1,0,0,0,0,0,0,            3'd0,0,1, 32'h0,        32'h0,         1,0,0);
    add(1,0,0,0,0,0,0,            3'd0,0,1, 32'h4,        32'h4,         1,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_wrap cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_wrap cyc %0d: pc=%h", cyc, bus0.pc_o);
      cyc++;
    end
  endtask

  task automatic test_halt();
    int cyc = 0;
    add(1,0,0,0,0,      1,32'h40, 3'd0,0,1, 32'h40, 32'h40,  1,1,0);
    add(1,0,1,0,0,      0,0,      3'd0,0,1, 32'h44, 32'h44,  0,0,1);
    add(1,0,1,1,32'h300,0,0,      3'd0,0,1, 32'h44, 32'h44,  0,0,1);
    add(1,0,1,0,0,      1,32'h700,3'd0,0,1, 32'h44, 32'h44,  0,0,1);
    add(1,0,0,0,0,      0,0,      3'd0,0,1, 32'h300,32'h300, 1,1,0);
    add(1,0,0,0,0,      0,0,      3'd0,0,1, 32'h304,32'h304, 1,0,0);
    add(1,0,1,0,0,      0,0,      3'd0,0,1, 32'h308,32'h308, 0,0,1);
    add(1,1,1,0,0,      0,0,      3'd0,0,1, 32'h0,  32'h0,   0,0,0);
    add(1,0,0,0,0,      0,0,      3'd0,0,1, 32'h0,  32'h0,   1,0,0);
    add(1,0,0,0,0,      0,0,      3'd0,0,1, 32'h4,  32'h4,   1,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_halt cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_halt cyc %0d: pc=%h valid=%b redirect=%b halted=%b", cyc, bus0.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0);
      cyc++;
    end
  endtask

  task automatic test_reset_stall();
    int cyc = 0;
    add(1,0,0,1,32'h600,0,0,3'd0,0,0, 32'h4,32'h4, 1,0,0);
    add(0,0,0,0,0,      0,0,3'd0,0,0, 32'h0,32'h0, 0,0,0);
    add(1,0,0,0,0,      0,0,3'd0,0,1, 32'h0,32'h0, 1,0,0);
    add(1,0,0,0,0,      0,0,3'd0,0,1, 32'h4,32'h4, 1,0,0);
    while (stim_q.size() > 0) begin
      exp_t e;
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (bus0.pc_o !== e.pc0 || bus1.pc_o !== e.pc1 || bus0.fetch_valid_o !== e.valid ||
          bus0.redirect_o !== e.redir || halted0 !== e.halted) begin
        n_errors++;
        $display("FAIL test_reset_stall cyc %0d: got pc=%h pc_c0=%h valid=%b redirect=%b halted=%b, want pc=%h pc_c0=%h valid=%b redirect=%b halted=%b",
                 cyc, bus0.pc_o, bus1.pc_o, bus0.fetch_valid_o, bus0.redirect_o, halted0,
                 e.pc0, e.pc1, e.valid, e.redir, e.halted);
      end else $display("test_reset_stall cyc %0d: pc=%h valid=%b redirect=%b", cyc, bus0.pc_o, bus0.fetch_valid_o, bus0.redirect_o);
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; jtag_reset = 1'b0; halt_req = 1'b0;
    trap_flag = 1'b0; trap_addr = '0; jump_flag = 1'b0; jump_addr = '0;
    hold = '0; comp = 1'b0;
    bus0.fetch_ready_i = 1'b0;
    bus1.fetch_ready_i = 1'b0;

    test_reset();
    test_sequential();
    test_comp();
    test_stall();
    test_trap_jump_hold();
    test_wrap();
    test_halt();
    test_reset_stall();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised successor to the core's program counter. Generates the fetch address with a valid/ready handshake to the instruction bus and supports 16-bit (compressed) stepping. Resolves trap and jump redirects by priority, buffering any redirect that arrives while a fetch is stalled, and provides a debug halt/resume state machine. Sits at the head of the fetch stage, driving the instruction-memory request and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, width of pc and redirect addresses
RESET_PC, 32'h0000_0000, pc value loaded on reset (ADDR_W bits used)
C_EXT, 1, 1 = 2-byte step/alignment allowed; 0 = 4-byte only
HOLD_W, 3, width of hold_flag_i bus; all-zero means no hold

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
jtag_reset_i  in  1  debug reset, synchronous, active-high, same effect as rst_n
halt_req_i  in  1  debug halt request, level
halted_o  out  1  1 while in HALT
trap_flag_i  in  1  trap redirect request, single cycle
trap_addr_i  in  ADDR_W  trap target
jump_flag_i  in  1  branch/jump redirect request, single cycle
jump_addr_i  in  ADDR_W  jump target
hold_flag_i  in  HOLD_W  pipeline hold; nonzero blocks advance
comp_i  in  1  instruction at pc_o is 16-bit (ignored when C_EXT=0)
fetch_valid_o  out  1  fetch request valid
fetch_ready_i  in  1  instruction bus accepts request
pc_o  out  ADDR_W  fetch address
redirect_o  out  1  one-cycle pulse: pc_o loaded from a redirect this cycle

Behaviour:
- Reset (rst_n=0 or jtag_reset_i=1, highest priority): pc_o=RESET_PC, fetch_valid_o=0, halted_o=0, redirect_o=0, pending cleared, state=BOOT.
- States: BOOT, RUN, HALT.
  - BOOT -> RUN after exactly one cycle. fetch_valid_o=0 in BOOT.
  - RUN: fetch_valid_o=1.
  - HALT: fetch_valid_o=0, halted_o=1.
- Handshake: fetch accepted when fetch_valid_o && fetch_ready_i. pc_o must not change while fetch_valid_o=1 && fetch_ready_i=0.
- Alignment: redirect targets have bit0 cleared (C_EXT=1) or bits[1:0] cleared (C_EXT=0) before use.
- RUN next-pc selection, evaluated on an accept cycle or when no request is outstanding:
  - trap_flag_i → trap_addr_i
  - else jump_flag_i → jump_addr_i
  - else pending valid → pending address
  - else if accept && hold_flag_i==0 → pc_o + step
  - else hold pc_o
- Step is 2 when C_EXT && comp_i, else 4. Arithmetic is modulo 2^ADDR_W (wraps to 0, no flag).
- Redirect while stalled (valid && !ready):
  - The redirect is captured in the pending register (addr + valid + is_trap) and pc_o is held.
  - The pending address is loaded into pc_o on the accept cycle. That accepted fetch belongs to the old pc and is flushed downstream.
  - A newer redirect overwrites pending, except a jump never overwrites a pending trap.
  - Same-cycle trap+jump: trap wins; the jump is discarded.
- A redirect on the accept cycle is loaded directly (1-cycle latency: pc_o = target on the next cycle). redirect_o=1 in the cycle pc_o shows the new target.
- Hold only blocks sequential advance. Redirects are applied even when hold_flag_i!=0.
- Halt:
  - RUN→HALT on an accept cycle with halt_req_i=1. pc_o is updated by the normal selection on that cycle.
  - In HALT: trap requests are latched into pending; jump requests are ignored.
  - HALT→RUN the cycle after halt_req_i=0. If pending is valid, pc_o is loaded from it on that transition (redirect_o=1).
- Reset mid-stall or mid-halt: everything returns to reset values; pending is dropped.

Test Plan:
- Reset release, ready=1, hold=0, comp=0, C_EXT=1:
  - BOOT 1 cycle with valid=0.
  - Then pc_o = 0x0, 0x4, 0x8, ... one step per cycle.
- comp_i=1 at pc=0x8:
  - Next pc=0xA.
  - With C_EXT=0, next pc=0xC.
  - Jump to 0x103 yields 0x102 (C_EXT=1) or 0x100 (C_EXT=0).
- ready=0 at pc=0x20, jump to 0x80 on stall cycle 1, trap to 0x200 on stall cycle 2, jump to 0x90 on stall cycle 3, ready=1 on cycle 5:
  - pc_o stays 0x20 throughout the stall.
  - Then pc_o=0x200 with redirect_o pulse.
- Simultaneous trap 0x400 + jump 0x500 with hold_flag_i=3'b010:
  - Next pc=0x400.
  - pc then holds until hold clears.
- pc=0xFFFF_FFFC, ready=1:
  - Next pc=0x0 (wrap).
- halt_req_i=1 at pc=0x40 with accept:
  - Next cycle halted_o=1, valid=0, pc=0x44.
  - Trap 0x300 during halt is latched.
  - After halt_req_i=0: pc=0x300, redirect_o=1, valid=1.
  - jtag_reset_i pulse during halt yields pc=RESET_PC, BOOT.
